conv1_mem_read: RTL and testbench

- Address generator for the Convolution 1 input image memory.
- Walks every 5x5 window of the 28x28 input image, one tap per enabled cycle, 25 cycles per output pixel.
- Also drives the matching kernel weight address and window framing strobes (first/last) to the conv1 MAC.
- Window rate matches the conv1 output-memory writer, which advances once per 25 cycles.

---
 rtl/conv1_mem_read_pkg.sv | 23 ++
 rtl/conv1_mem_read_if.sv | 43 ++++
 rtl/conv1_mem_read_counter.sv | 25 ++
 rtl/conv1_mem_read.sv | 116 +++++++++++
 tb/tb_conv1_mem_read.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/conv1_mem_read_pkg.sv
// Shared constants and types for the conv1 input-image read path.
// Optional pixel-index output is enabled with CONV1_RD_PIXIDX_EN.
package conv_pkg;

  localparam int IMG_W  = 28;
  localparam int K      = 5;
  localparam int OUT_W  = IMG_W - K + 1;
  localparam int N_TAPS = K * K;
  localparam int N_WIN  = OUT_W * OUT_W;

  localparam int IMG_AW = 10;
  localparam int WT_AW  = 5;
  localparam int PIX_AW = 10;

  // next kernel row, and next output row
  localparam int ROW_STEP = IMG_W - K + 1;
  localparam int WIN_ROW_STEP = IMG_W - OUT_W + 1;

  typedef logic [IMG_AW-1:0] img_addr_t;
  typedef logic [WT_AW-1:0]  wt_addr_t;
  typedef logic [PIX_AW-1:0] pix_idx_t;

endpackage

// File: rtl/conv1_mem_read_if.sv
// Address/framing bundle between the conv1 reader and the MAC.
// Carries pix_idx only when CONV1_RD_PIXIDX_EN is defined.
interface conv1_mem_read_if;
  import conv_pkg::*;

  logic      enable;
  img_addr_t img_addr;
  wt_addr_t  wt_addr;
  logic      first;
  logic      last;
  logic      valid;
  logic      done;
`ifdef CONV1_RD_PIXIDX_EN
  pix_idx_t  pix_idx;
`endif

  modport master (
    input  enable,
    output img_addr,
    output wt_addr,
    output first,
    output last,
    output valid,
`ifdef CONV1_RD_PIXIDX_EN
    output pix_idx,
`endif
    output done
  );

  modport slave (
    output enable,
    input  img_addr,
    input  wt_addr,
    input  first,
    input  last,
    input  valid,
`ifdef CONV1_RD_PIXIDX_EN
    input  pix_idx,
`endif
    input  done
  );

endinterface

// File: rtl/conv1_mem_read_counter.sv
// Wrap counter 0..MAX; co flags terminal count so stages can chain.
module mod_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output logic co
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] q;

  assign co = (q == W'(MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (inc) begin
      q <= co ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/conv1_mem_read.sv
// Conv1 input-image address generator: 5x5 taps per 24x24 window.
// Define CONV1_RD_PIXIDX_EN to add the pix_idx output.
module conv1_mem_read
  import conv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  conv1_mem_read_if.master bus
);

  logic      adv;
  logic      step;
  logic      fin;
  logic      win_end;
  logic      win_step;
  logic      kc_co;
  logic      kr_co;
  logic      oc_co;
  logic      or_co;
  img_addr_t win_base;
  img_addr_t tap_off;
  wt_addr_t  wt_q;
  logic      done_q;

  assign adv      = bus.enable && !done_q;
  assign win_end  = kc_co && kr_co;
  assign fin      = win_end && oc_co && or_co;
  // the final tap only raises done; every counter holds
  assign step     = adv && !fin;
  assign win_step = step && win_end;

  mod_counter #(.MAX(K - 1)) u_kc (
    .clk   (clk),
    .reset (reset),
    .inc   (step),
    .co    (kc_co)
  );

  mod_counter #(.MAX(K - 1)) u_kr (
    .clk   (clk),
    .reset (reset),
    .inc   (step && kc_co),
    .co    (kr_co)
  );

  mod_counter #(.MAX(OUT_W - 1)) u_oc (
    .clk   (clk),
    .reset (reset),
    .inc   (win_step),
    .co    (oc_co)
  );

  mod_counter #(.MAX(OUT_W - 1)) u_or (
    .clk   (clk),
    .reset (reset),
    .inc   (win_step && oc_co),
    .co    (or_co)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_off <= '0;
      wt_q    <= '0;
    end else if (step) begin
      if (!kc_co) begin
        tap_off <= tap_off + IMG_AW'(1);
        wt_q    <= wt_q + WT_AW'(1);
      end else if (!kr_co) begin
        tap_off <= tap_off + IMG_AW'(ROW_STEP);
        wt_q    <= wt_q + WT_AW'(1);
      end else begin
        tap_off <= '0;
        wt_q    <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_base <= '0;
    end else if (win_step) begin
      win_base <= win_base + (oc_co ? IMG_AW'(WIN_ROW_STEP)
                                    : IMG_AW'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else if (adv && fin) begin
      done_q <= 1'b1;
    end
  end

`ifdef CONV1_RD_PIXIDX_EN
  pix_idx_t pix_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_q <= '0;
    end else if (win_step) begin
      pix_q <= pix_q + PIX_AW'(1);
    end
  end

  assign bus.pix_idx = pix_q;
`endif

  assign bus.img_addr = win_base + tap_off;
  assign bus.wt_addr  = wt_q;
  assign bus.first    = (wt_q == '0);
  assign bus.last     = (wt_q == WT_AW'(N_TAPS - 1));
  assign bus.valid    = adv;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_conv1_mem_read.sv
// Directed bench for conv1_mem_read: tap order, pause, done, async reset.
module tb_conv1_mem_read;

  logic clk;
  logic reset;
  int   errs;
  int   checks;

  conv1_mem_read_if bus ();

  conv1_mem_read dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_img(input int g);
    int w;
    int t;
    w = g / 25;
    t = g % 25;
    return (w / 24) * 28 + (w % 24) + (t / 5) * 28 + (t % 5);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_tap(input int g);
    chk("img", 32'(bus.img_addr), 32'(exp_img(g)));
    chk("wt", 32'(bus.wt_addr), 32'(g % 25));
    chk("first", 32'(bus.first), 32'(g % 25 == 0));
    chk("last", 32'(bus.last), 32'(g % 25 == 24));
    chk("valid", 32'(bus.valid), 32'd1);
`ifdef CONV1_RD_PIXIDX_EN
    chk("pix", 32'(bus.pix_idx), 32'(g / 25));
`endif
  endtask

  task automatic run(input int from, input int to);
    for (int g = from; g < to; g++) begin
      check_tap(g);
      if (g == 25) begin
        chk("win1_img", 32'(bus.img_addr), 32'd1);
        chk("win1_first", 32'(bus.first), 32'd1);
      end
      if (g == 24 * 25)
        chk("win24_img", 32'(bus.img_addr), 32'd28);
      if (g == 23 * 25 + 24)
        chk("win23_end", 32'(bus.img_addr), 32'd139);
      if (g == 14399) begin
        chk("fin_img", 32'(bus.img_addr), 32'd783);
        chk("fin_last", 32'(bus.last), 32'd1);
        chk("fin_done0", 32'(bus.done), 32'd0);
      end
      tick();
    end
  endtask

  task automatic check_done();
    chk("done", 32'(bus.done), 32'd1);
    chk("done_valid", 32'(bus.valid), 32'd0);
    chk("done_img", 32'(bus.img_addr), 32'd783);
    chk("done_wt", 32'(bus.wt_addr), 32'd24);
`ifdef CONV1_RD_PIXIDX_EN
    chk("done_pix", 32'(bus.pix_idx), 32'd575);
`endif
  endtask

  initial begin
    errs       = 0;
    checks     = 0;
    reset      = 1'b0;
    bus.enable = 1'b0;
    #12;
    chk("rst_img", 32'(bus.img_addr), 32'd0);
    chk("rst_wt", 32'(bus.wt_addr), 32'd0);
    chk("rst_first", 32'(bus.first), 32'd1);
    chk("rst_last", 32'(bus.last), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    tick();

    // first window plus half of the second, then a pause
    bus.enable = 1'b1;
    #1;
    run(0, 38);
    bus.enable = 1'b0;
    #1;
    for (int i = 0; i < 7; i++) begin
      chk("hold_img", 32'(bus.img_addr), 32'(exp_img(38)));
      chk("hold_wt", 32'(bus.wt_addr), 32'd13);
      chk("hold_valid", 32'(bus.valid), 32'd0);
      tick();
    end
    bus.enable = 1'b1;
    #1;
    run(38, 14400);
    check_done();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_done();
    end

    // restart, then reset asynchronously mid-run at window 300
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    run(0, 300 * 25 + 10);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_img", 32'(bus.img_addr), 32'd0);
    chk("arst_wt", 32'(bus.wt_addr), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_first", 32'(bus.first), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    run(0, 14400);
    check_done();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
